// File: rtl/axis_frame_pkg.sv
// Shared definitions for the AXIS frame transmitter and receiver pair:
// frame FSM states, beat width and the tail-beat byte-enable helper.
package axis_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } frame_state_e;

  localparam int BEAT_BYTES = 4;

  // Contiguous byte enables from bit 0 for a beat with `remaining` bytes left in the frame.
  function automatic logic [3:0] keep_from_remaining(input logic [31:0] remaining);
    logic [3:0] keep;
    keep = 4'b0000;
    if (remaining >= 32'd4) begin
      keep = 4'b1111;
    end else begin
      case (remaining[1:0])
        2'd1:    keep = 4'b0001;
        2'd2:    keep = 4'b0011;
        2'd3:    keep = 4'b0111;
        default: keep = 4'b0000;
      endcase
    end
    return keep;
  endfunction

endpackage

// File: rtl/m_axis_frame_tx.sv
// AXI-Stream frame transmitter: streams data_buf[0 .. len-1] as 32-bit beats with tkeep/tlast.
// Optional early termination input is enabled by defining AXIS_TX_ABORT_EN.
module m_axis_frame_tx
  import axis_frame_pkg::*;
#(
  parameter int FIFO_SIZE      = 1024,
  parameter int FIFO_ADDR_SIZE = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [FIFO_SIZE-1:0][7:0]     data_buf,
  input  logic [FIFO_ADDR_SIZE-1:0]     data_len,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   m_axis_tdata,
  output logic [3:0]                    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
`ifdef AXIS_TX_ABORT_EN
  input  logic                          abort,
  output logic                          aborted,
`endif
  input  logic                          m_axis_tready
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int BW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam logic [FIFO_ADDR_SIZE-1:0] MAX_LEN   = FIFO_ADDR_SIZE'(FIFO_SIZE);
  localparam logic [FIFO_ADDR_SIZE-1:0] BEAT_STEP = FIFO_ADDR_SIZE'(BEAT_BYTES);

  // Handshake: a beat transfers on a rising edge where m_axis_tvalid && m_axis_tready; while
  // tvalid is high and tready low, tdata/tkeep/tlast hold and tvalid stays high.

  logic [1:0]                state;
  logic [FIFO_ADDR_SIZE-1:0] ptr;
  logic [FIFO_ADDR_SIZE-1:0] len_q;

  logic [FIFO_ADDR_SIZE-1:0] len_clamped;
  logic [FIFO_ADDR_SIZE-1:0] load_ptr;
  logic [FIFO_ADDR_SIZE-1:0] load_len;
  logic [FIFO_ADDR_SIZE-1:0] remaining;
  logic [FIFO_ADDR_SIZE-1:0] byte_idx [BEAT_BYTES];
  logic [31:0]               load_data;
  logic [3:0]                load_keep;
  logic                      load_last;
  logic                      force_last;
  logic                      handshake;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign handshake = m_axis_tvalid && m_axis_tready;

  // One beat loader serves both the first beat (from IDLE) and each following beat.
  always_comb begin
    len_clamped = (data_len > MAX_LEN) ? MAX_LEN : data_len;
    load_ptr    = (state == IDLE) ? '0 : ptr + BEAT_STEP;
    load_len    = (state == IDLE) ? len_clamped : len_q;
    remaining   = load_len - load_ptr;
    load_data   = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      byte_idx[i] = load_ptr + FIFO_ADDR_SIZE'(i);
      if (byte_idx[i] < MAX_LEN) begin
        load_data[8*i +: 8] = data_buf[byte_idx[i][BW-1:0]];
      end
    end
    load_keep = keep_from_remaining(32'(remaining));
    load_last = (remaining <= BEAT_STEP);
  end

`ifdef AXIS_TX_ABORT_EN
  logic abort_q;
  logic aborted_q;

  assign force_last = (state == SEND) && (abort_q || abort) && !m_axis_tlast;
  assign aborted    = done && aborted_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else if (state != SEND) begin
      abort_q <= 1'b0;
      if (state == IDLE) aborted_q <= 1'b0;
    end else if (handshake && !m_axis_tlast) begin
      abort_q <= 1'b0;
      if (force_last) aborted_q <= 1'b1;
    end else if (abort && !m_axis_tlast) begin
      abort_q <= 1'b1;
    end
  end
`else
  assign force_last = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      ptr           <= '0;
      len_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= '0;
            len_q <= len_clamped;
            if (len_clamped == '0) begin
              state <= DONE;
            end else begin
              state         <= SEND;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= load_data;
              m_axis_tkeep  <= load_keep;
              m_axis_tlast  <= load_last;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            if (m_axis_tlast) begin
              state         <= DONE;
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
              m_axis_tkeep  <= '0;
              m_axis_tlast  <= 1'b0;
            end else begin
              ptr          <= load_ptr;
              m_axis_tdata <= load_data;
              m_axis_tkeep <= load_keep;
              m_axis_tlast <= load_last || force_last;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_axis_frame_tx.sv
// Self-checking bench for m_axis_frame_tx: randomized buffers and ready patterns
// scored against a beat list computed from the frame rules.
module tb_m_axis_frame_tx;

  localparam int FS = 1024;
  localparam int AW = 16;

  logic                 aclk = 1'b0;
  logic                 areset = 1'b0;
  logic [FS-1:0][7:0]   data_buf;
  logic [AW-1:0]        data_len;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [31:0]          m_axis_tdata;
  logic [3:0]           m_axis_tkeep;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
`ifdef AXIS_TX_ABORT_EN
  logic                 abort;
  logic                 aborted;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  m_axis_frame_tx #(.FIFO_SIZE(FS), .FIFO_ADDR_SIZE(AW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .data_buf      (data_buf),
    .data_len      (data_len),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_TX_ABORT_EN
    .abort         (abort),
    .aborted       (aborted),
`endif
    .m_axis_tready (m_axis_tready)
  );

  // ---------------- reference model ----------------
  // Frame of min(len, FS) bytes cut into ceil(L/4) beats; beat j covers offsets 4j..4j+3.
  function automatic void build_exp(input int len);
    int l;
    int nb;
    int idx;
    logic [31:0] d;
    logic [3:0]  k;
    l  = (len > FS) ? FS : len;
    nb = (l + 3) / 4;
    exp_q.delete();
    for (int j = 0; j < nb; j++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < 4; i++) begin
        idx = 4 * j + i;
        if (idx < FS) d[8*i +: 8] = data_buf[idx];
        if (idx < l)  k[i] = 1'b1;
      end
      exp_q.push_back({(j == nb - 1), k, d});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int k = 0; k < FS; k++) data_buf[k] = 8'($urandom);
  endtask

  task automatic fill_seq(input int n);
    for (int k = 0; k < FS; k++) data_buf[k] = (k < n) ? 8'(k + 1) : 8'h00;
  endtask

  // ready_pct < 0 selects the fixed pattern: tready low on cycles 1..3.
  // Scores every handshake against exp_q, AXIS hold behaviour, busy and done timing.
  task automatic send_frame(input int len, input int ready_pct, input int mid_start_at,
                            input int abort_at);
    int          last_hs;
    bit          fin;
    bit          prev_stall;
    logic [36:0] prev;
    logic [36:0] cur;
    logic [36:0] e;
    last_hs    = -1;
    fin        = 1'b0;
    prev_stall = 1'b0;
    prev       = '0;
    obs_q.delete();
    @(negedge aclk);
    data_len = AW'(len);
    start    = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (ready_pct < 0) m_axis_tready = !(cyc >= 1 && cyc <= 3);
      else               m_axis_tready = ($urandom_range(1, 100) <= ready_pct);
      start = (cyc == mid_start_at);
`ifdef AXIS_TX_ABORT_EN
      abort = (cyc == abort_at);
`endif
      cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_frame: cycle %0d got %b expected 1", cyc, busy);
      end
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b beat=%h expected valid=1 beat=%h",
                   m_axis_tvalid, cur, prev);
        end
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (last_hs != cyc - 1 || m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL done_timing: done at cycle %0d valid=%b expected cycle %0d valid=0",
                   cyc, m_axis_tvalid, last_hs + 1);
        end
`ifdef AXIS_TX_ABORT_EN
        checks++;
        if (aborted !== (abort_at >= 0)) begin
          errors++;
          $display("FAIL aborted_flag: got %b expected %b", aborted, (abort_at >= 0));
        end
`endif
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        obs_q.push_back(cur);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat_%0d: got %h expected %h", obs_q.size(), cur, e);
          end
        end
        if (m_axis_tlast) last_hs = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev       = cur;
      @(negedge aclk);
    end
    start = 1'b0;
`ifdef AXIS_TX_ABORT_EN
    abort = 1'b0;
`endif
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL frame_timeout: got no done within budget expected done");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_beats: got %0d beats short expected 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got busy=%b done=%b valid=%b expected 0/0/0",
               busy, done, m_axis_tvalid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    start         = 1'b0;
    data_len      = '0;
    m_axis_tready = 1'b0;
`ifdef AXIS_TX_ABORT_EN
    abort = 1'b0;
`endif
    fill_random();
    #2 areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if ({busy, done, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b last=%b keep=%h data=%h expected all 0",
               busy, done, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata);
    end
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({busy, done, m_axis_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, done, m_axis_tvalid});
    end
  endtask

  task automatic test_len8();
    fill_random();
    build_exp(8);
    send_frame(8, 100, -1, -1);
    checks++;
    if (obs_q.size() != 2 || obs_q[0][36:32] !== 5'b0_1111 || obs_q[1][36:32] !== 5'b1_1111) begin
      errors++;
      $display("FAIL len8_shape: got %0d beats expected 2 with keep 1111 and tlast on beat 2",
               obs_q.size());
    end
  endtask

  task automatic test_len5();
    fill_seq(5);
    build_exp(5);
    send_frame(5, 100, -1, -1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL len5_count: got %0d expected 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {1'b0, 4'hf, 32'h04030201} || obs_q[1] !== {1'b1, 4'h1, 32'h00000005}) begin
        errors++;
        $display("FAIL len5_beats: got %h %h expected %h %h", obs_q[0], obs_q[1],
                 {1'b0, 4'hf, 32'h04030201}, {1'b1, 4'h1, 32'h00000005});
      end
    end
  endtask

  task automatic test_zero_len();
    fill_random();
    build_exp(0);
    send_frame(0, 100, -1, -1);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len_beats: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_stall();
    fill_random();
    build_exp(12);
    send_frame(12, -1, -1, -1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 3", obs_q.size());
    end
  endtask

  task automatic test_clamp_and_busy_start();
    fill_random();
    build_exp(2000);
    send_frame(2000, 100, 50, -1);
    checks++;
    if (obs_q.size() != 256 || obs_q[obs_q.size()-1][36] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_count: got %0d beats expected 256 ending in tlast", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [36:0] cur;
    logic [36:0] e;
    int          hs;
    fill_random();
    build_exp(40);
    hs = 0;
    @(negedge aclk);
    data_len      = AW'(40);
    m_axis_tready = 1'b1;
    start         = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && hs < 2; cyc++) begin
      if (m_axis_tvalid === 1'b1) begin
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        e   = exp_q.pop_front();
        checks++;
        if (cur !== e) begin
          errors++;
          $display("FAIL pre_reset_beat: got %h expected %h", cur, e);
        end
        hs++;
      end
      @(negedge aclk);
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== exp_q[0]) begin
      errors++;
      $display("FAIL beat3_presented: got valid=%b beat=%h expected valid=1 beat=%h",
               m_axis_tvalid, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q[0]);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_valid: got valid=%b busy=%b expected 0/0", m_axis_tvalid, busy);
    end
    @(negedge aclk);
    areset = 1'b0;
    build_exp(40);
    send_frame(40, 100, -1, -1);
  endtask

  task automatic test_random_frames();
    int len;
    for (int n = 0; n < 8; n++) begin
      fill_random();
      len = $urandom_range(1, 70);
      build_exp(len);
      send_frame(len, 60, -1, -1);
    end
  endtask

`ifdef AXIS_TX_ABORT_EN
  task automatic test_abort();
    logic [36:0] b3;
    fill_random();
    build_exp(40);
    b3 = exp_q[2];
    b3[36] = 1'b1;
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    exp_q.push_back(b3);
    send_frame(40, 100, -1, 1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL abort_count: got %0d expected 3", obs_q.size());
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_len8();
    test_len5();
    test_zero_len();
    test_stall();
    test_clamp_and_busy_start();
    test_reset_mid_frame();
    test_random_frames();
`ifdef AXIS_TX_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
